// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter in front of a FIFO controller. Once a requester
//   wins with a non-last beat, the arbiter locks onto it until that requester
//   sends its last beat, so packets are never interleaved in the FIFO.
//
// Ports
//   i_clk      clock, all state on rising edge
//   i_rstn     asynchronous active-low reset
//   i_req      [N]    per-requester valid
//   i_last     [N]    per-requester end-of-packet, qualified by i_req
//   i_data     [N*W]  requester k data at [k*W +: W]
//   i_full     FIFO full; blocks every grant
//   o_gnt      [N]    one-hot-or-zero grant (ready back to requester)
//   o_wr       FIFO write strobe
//   o_wdata    [W]    data of the granted requester, zero when no write
//   o_busy     high while a packet is locked to one owner
//   o_owner    [3]    locked owner, else current idle winner, else 0
//   o_wr_cnt   [16]   accepted writes, saturating
module fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_last,
    input  logic [N*W-1:0] i_data,
    input  logic           i_full,
    output logic [N-1:0]   o_gnt,
    output logic           o_wr,
    output logic [W-1:0]   o_wdata,
    output logic           o_busy,
    output logic [2:0]     o_owner,
    output logic [15:0]    o_wr_cnt
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]     r_state;
    logic [2:0]     r_rr_ptr;
    logic [2:0]     r_owner;
    logic [15:0]    r_wr_cnt;

    logic [2*N-1:0] w_dbl;
    logic [2:0]     w_win;
    logic           w_any;
    logic [3:0]     w_sum;
    logic           w_locked;
    logic [2:0]     w_sel;
    logic           w_gnt_en;
    logic [N-1:0]   w_gnt;
    logic [W-1:0]   w_data;
    logic           w_last;
    logic           w_wr;
    logic [2:0]     w_nxt;

    assign w_locked = (r_state == S_LOCKED);

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set
    // bit of the rotated vector is then the round-robin winner.
    assign w_dbl = {i_req, i_req} >> r_rr_ptr;

    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_sum = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + 4'(i);
                if (w_sum >= 4'(N))
                    w_sum = w_sum - 4'(N);
                w_win = w_sum[2:0];
            end
        end
    end

    // Locked: the owner keeps the grant even with its request low, so the
    // grant can be offered but no write happens until it raises i_req again.
    assign w_sel    = w_locked ? r_owner : w_win;
    assign w_gnt_en = i_rstn & ~i_full & (w_locked | w_any);

    always_comb begin
        w_gnt  = '0;
        w_data = '0;
        w_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == 3'(k)) begin
                w_gnt[k] = w_gnt_en;
                w_data   = i_data[k*W +: W];
                w_last   = i_last[k];
            end
        end
    end

    assign w_wr  = |(w_gnt & i_req);
    assign w_nxt = (w_sel == 3'(N - 1)) ? 3'd0 : w_sel + 3'd1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_wr_cnt <= '0;
        end else if (w_wr) begin
            if (r_wr_cnt != 16'hFFFF)
                r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_last) begin
                // Single-beat idle packets and closing beats both hand the
                // pointer to the requester after the one just served.
                r_state  <= S_IDLE;
                r_rr_ptr <= w_nxt;
            end else if (!w_locked) begin
                r_state  <= S_LOCKED;
                r_owner  <= w_sel;
            end
        end
    end

    assign o_gnt    = w_gnt;
    assign o_wr     = w_wr;
    assign o_wdata  = w_wr ? w_data : '0;
    assign o_busy   = w_locked;
    assign o_owner  = !i_rstn ? 3'd0 : (w_locked ? r_owner : (w_any ? w_win : 3'd0));
    assign o_wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  wdata;
    logic        busy;
    logic [2:0]  owner;
    logic [15:0] cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] i_req, i_last;
  logic [N*W-1:0] i_data;
  logic         i_full;
  logic [N-1:0] o_gnt;
  logic         o_wr;
  logic [W-1:0] o_wdata;
  logic         o_busy;
  logic [2:0]   o_owner;
  logic [15:0]  o_wr_cnt;

  int checks = 0;
  int failures = 0;

  exp_t q[$];
  exp_t mon_e;

  // reference model state
  bit m_locked;
  int m_owner, m_rr, m_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(N), .W(W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(i_req), .i_last(i_last),
    .i_data(i_data), .i_full(i_full), .o_gnt(o_gnt), .o_wr(o_wr),
    .o_wdata(o_wdata), .o_busy(o_busy), .o_owner(o_owner), .o_wr_cnt(o_wr_cnt)
  );

  function automatic bit bit_of(input logic [N-1:0] v, input int idx);
    return ((int'(v) >> idx) & 1) != 0;
  endfunction

  // Outputs the arbiter should present for the current inputs and model state.
  function automatic exp_t predict();
    exp_t e;
    int sel, best;
    e = '0;
    best = -1;
    if (!rstn) return e;
    if (m_locked) sel = m_owner;
    else begin
      for (int d = 0; d < N; d++)
        if (best < 0 && bit_of(i_req, (m_rr + d) % N)) best = (m_rr + d) % N;
      sel = best;
    end
    if (sel >= 0 && !i_full) e.gnt = 4'(1 << sel);
    e.wr = (e.gnt & i_req) != 0;
    if (e.wr) e.wdata = 8'(i_data >> (sel * W));
    e.busy  = m_locked;
    e.owner = m_locked ? 3'(m_owner) : (best >= 0 ? 3'(best) : 3'd0);
    e.cnt   = 16'(m_cnt);
    return e;
  endfunction

  task automatic advance(input exp_t e);
    int sel;
    if (!rstn) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
      return;
    end
    if (!e.wr) return;
    if (m_cnt < 65535) m_cnt++;
    sel = 0;
    for (int k = 0; k < N; k++) if (e.gnt[k]) sel = k;
    if (bit_of(i_last, sel)) begin
      m_locked = 0;
      m_rr = (sel + 1) % N;
    end else if (!m_locked) begin
      m_locked = 1;
      m_owner = sel;
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] last,
                      input logic full, input logic rn);
    exp_t e;
    @(posedge clk); #1;
    rstn = rn; i_req = req; i_last = last; i_full = full; i_data = $urandom;
    e = predict();
    q.push_back(e);
    advance(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: compares every presented output cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (o_gnt !== mon_e.gnt || o_wr !== mon_e.wr || o_wdata !== mon_e.wdata ||
          o_busy !== mon_e.busy || o_owner !== mon_e.owner || o_wr_cnt !== mon_e.cnt) begin
        failures++;
        $display("FAIL scoreboard t=%0t gnt=%b/%b wr=%b/%b wdata=%h/%h busy=%b/%b owner=%0d/%0d cnt=%0d/%0d (actual/expected)",
                 $time, o_gnt, mon_e.gnt, o_wr, mon_e.wr, o_wdata, mon_e.wdata,
                 o_busy, mon_e.busy, o_owner, mon_e.owner, o_wr_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    rstn = 1'b0; i_req = '0; i_last = '0; i_data = '0; i_full = 1'b0;
    m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;

    // reset with requests present: everything must stay zero
    step(4'b1111, 4'b1111, 1'b0, 1'b0); #1;
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_owner", 32'(o_owner), 32'h0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // all requesters, single-beat packets: rotate 0,1,2,3
    step(4'b1111, 4'b1111, 1'b0, 1'b1); #1; chk("rr_g0", 32'(o_gnt), 32'h1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1); #1; chk("rr_g1", 32'(o_gnt), 32'h2);
    step(4'b1111, 4'b1111, 1'b0, 1'b1); #1; chk("rr_g2", 32'(o_gnt), 32'h4);
    step(4'b1111, 4'b1111, 1'b0, 1'b1); #1; chk("rr_g3", 32'(o_gnt), 32'h8);
    step(4'b0000, 4'b0000, 1'b0, 1'b1); #1; chk("rr_cnt", 32'(o_wr_cnt), 32'd4);

    // move pointer to 2, then 3-beat packet from requester 2 vs 0 and 1
    step(4'b0010, 4'b0010, 1'b0, 1'b1);
    step(4'b0111, 4'b0000, 1'b0, 1'b1); #1; chk("pkt_b1", 32'(o_gnt), 32'h4);
    step(4'b0111, 4'b0000, 1'b0, 1'b1); #1; chk("pkt_b2", 32'(o_gnt), 32'h4);
    chk("pkt_busy", 32'(o_busy), 32'h1);
    step(4'b0111, 4'b0100, 1'b0, 1'b1); #1; chk("pkt_b3", 32'(o_gnt), 32'h4);
    step(4'b0011, 4'b0011, 1'b0, 1'b1); #1; chk("pkt_wrap", 32'(o_gnt), 32'h1);

    // lock on owner 1, FIFO full for two cycles
    step(4'b0010, 4'b0000, 1'b0, 1'b1); #1; chk("full_lock", 32'(o_gnt), 32'h2);
    step(4'b0011, 4'b0000, 1'b1, 1'b1); #1; chk("full_gnt", 32'(o_gnt), 32'h0);
    chk("full_wr", 32'(o_wr), 32'h0);
    chk("full_owner", 32'(o_owner), 32'h1);
    step(4'b0011, 4'b0000, 1'b1, 1'b1); #1; chk("full_busy", 32'(o_busy), 32'h1);
    step(4'b0010, 4'b0010, 1'b0, 1'b1); #1; chk("full_resume", 32'(o_gnt), 32'h2);

    // lock on owner 0, owner idles while requester 3 waits
    step(4'b0001, 4'b0000, 1'b0, 1'b1); #1; chk("drop_lock", 32'(o_gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 4'b1000, 1'b0, 1'b1); #1;
      chk("drop_gnt", 32'(o_gnt), 32'h1);
      chk("drop_wr", 32'(o_wr), 32'h0);
    end
    step(4'b1001, 4'b0001, 1'b0, 1'b1); #1; chk("drop_last", 32'(o_gnt), 32'h1);
    step(4'b1000, 4'b1000, 1'b0, 1'b1); #1; chk("drop_r3", 32'(o_gnt), 32'h8);

    // reset in the middle of a packet from requester 2
    step(4'b0100, 4'b0000, 1'b0, 1'b1);
    step(4'b0100, 4'b0000, 1'b0, 1'b0); #1;
    chk("mrst_busy", 32'(o_busy), 32'h0);
    chk("mrst_gnt", 32'(o_gnt), 32'h0);
    chk("mrst_cnt", 32'(o_wr_cnt), 32'h0);
    step(4'b0100, 4'b0100, 1'b0, 1'b1); #1; chk("mrst_one", 32'(o_gnt), 32'h4);
    step(4'b1111, 4'b1111, 1'b0, 1'b1); #1; chk("mrst_next", 32'(o_gnt), 32'h8);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 99) != 0));
    end

    // saturation of the write counter
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1); #1; chk("sat_reach", 32'(o_wr_cnt), 32'hFFFF);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1); #1; chk("sat_hold", 32'(o_wr_cnt), 32'hFFFF);

    @(negedge clk); #1;
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
